led_pwm_palette_driver: RTL and testbench
=========================================

Name: led_pwm_palette_driver

Overview:
- Consumer end of the LED palette interface: takes per-LED 8-bit palette values (red/green/blue for color LEDs, luminance for basic LEDs) and emits one PWM bit per LED channel to the board pins.
- Sits between the palette pulser and the top-level LED outputs.
- Palette values are double-buffered and applied only at a PWM period boundary, so pins never glitch mid-period.

Parameters:
- parm_color_led_count, 4, number of RGB LEDs
- parm_basic_led_count, 4, number of single-color LEDs
- parm_FCLK, 40_000_000, i_clk frequency in Hz
- parm_pwm_freq_hz, 9_765, PWM period rate; tick divisor = max(1, parm_FCLK / (parm_pwm_freq_hz * 256)), default 16

Ports:
- i_clk  in  1  system clock
- i_srst  in  1  reset, asynchronous, active-high
- i_color_led_red_value  in  8*parm_color_led_count  red palette; LED k at bits [8k+7:8k]
- i_color_led_green_value  in  8*parm_color_led_count  green palette, same packing
- i_color_led_blue_value  in  8*parm_color_led_count  blue palette, same packing
- i_basic_led_lumin_value  in  8*parm_basic_led_count  basic LED luminance, same packing
- o_color_led_red  out  parm_color_led_count  red PWM bit per LED
- o_color_led_green  out  parm_color_led_count  green PWM bit per LED
- o_color_led_blue  out  parm_color_led_count  blue PWM bit per LED
- o_basic_led_lumin  out  parm_basic_led_count  basic LED PWM bit per LED

Behaviour:
- Clock and reset: one clock, i_clk. i_srst is asynchronous and active-high.
- Reset values: all outputs 0; period counter 8'hFF; all shadow registers 0; tick divider restarts.
- Tick: a clock_enable_divider instance with par_ce_divisor = tick divisor and i_ce_mhz = 1 produces a one-cycle s_pwm_ce.
- Period counter: 8-bit, advances only on s_pwm_ce, 0..255, wraps 255→0. One PWM period = 256 ticks.
- Wrap tick (s_pwm_ce with counter==255):
  - counter <= 0
  - every shadow register <= its current input slice
  - each output <= (input slice != 0)
- Other ticks: counter <= counter+1; each output <= ((counter+1) < shadow).
- Between ticks: counter, shadows and outputs hold.
- Duty: value V gives V/256 duty. 0 means always off; 255 means on for 255 of 256 ticks. No full-on state.
- Latency: an input change is sampled at the next wrap tick; the output reflects it on the clock edge of that tick, so worst case is one full period plus one tick.
- Input changes mid-period are ignored until the next wrap. Inputs need not be stable except at the wrap tick.
- All channels compare against the same counter, so switching is phase-aligned unless the optional feature is enabled.
- Reset asserted mid-period: outputs drop to 0 immediately. After release, the first tick is a wrap tick (counter 255) and loads fresh inputs.

Optional Feature:
- Macro: LED_PWM_PHASE_STAGGER_EN.
- Defined: within each group, LED index k compares against the phase counter (counter + k*64) mod 256 in place of counter. This spreads rising edges to reduce simultaneous switching current.
  - Duty cycle is unchanged.
  - Shadow load still occurs only at the global counter wrap.
- Undefined: every channel uses the unstaggered counter, exactly as in Behaviour.

Decomposition:
- Package led_pwm_pkg:
  - c_pwm_steps = 256
  - c_pwm_phase_step = 64
  - typedef t_pwm_value = logic [7:0]
  - function for the tick-divisor computation with the clamp to 1
- Sub-module led_pwm_channel: one 8-bit shadow register plus comparator plus output flop, with inputs for the tick, wrap flag and phase counter. Instantiate it via generate, once per color component and once per basic LED.

Test Plan:
- parm_FCLK = 256*parm_pwm_freq_hz (divisor 1), red LED0 = 8'h40, all others 0 → o_color_led_red[0] high for exactly 64 of every 256 cycles; all other outputs constantly 0.
- Basic LED2 = 8'h00 then 8'hFF → output always 0, then 255 cycles high and 1 cycle low per period.
- Change green LED1 from 8'h10 to 8'hC0 at counter 100 → the current period keeps 16 high ticks; 192 high ticks begin exactly at the next wrap.
- Assert i_srst asynchronously (off a clock edge) with outputs high → all outputs 0 without waiting for a clock edge. Release → the first tick reloads inputs and LED outputs with nonzero values go high.
- Default parameters (divisor 16), blue LED3 = 8'h80 → high for 2048 of every 4096 clocks.
- With LED_PWM_PHASE_STAGGER_EN, all four red values = 8'h40 → rising edges offset by 64 ticks between LED k and k+1; each duty stays 64/256.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg
//   Shared constants, the PWM value type and the tick-divisor helper for the
//   LED PWM palette driver.
//   Optional feature macro: LED_PWM_PHASE_STAGGER_EN (used by the top level).
package led_pwm_pkg;

  localparam int c_pwm_steps      = 256;  // ticks per PWM period
  localparam int c_pwm_phase_step = 64;   // phase offset between adjacent LEDs when staggered

  typedef logic [7:0] t_pwm_value;

  // Clock cycles per PWM tick. Clamped to 1 so a slow clock or a fast PWM
  // rate degenerates to "tick every cycle" rather than a zero divisor.
  function automatic int calc_tick_divisor(input int fclk, input int pwm_freq_hz);
    int q;
    q = fclk / (pwm_freq_hz * c_pwm_steps);
    if (q < 1) q = 1;
    return q;
  endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// clock_enable_divider
//   Produces a one-cycle clock-enable pulse every par_ce_divisor cycles in
//   which i_ce_mhz is high. With a divisor of 1, o_ce simply follows i_ce_mhz.
// Ports:
//   i_clk     system clock
//   i_srst    asynchronous active-high reset (restarts the division)
//   i_ce_mhz  upstream enable, counted cycles
//   o_ce      divided enable pulse
module clock_enable_divider #(
  parameter int par_ce_divisor = 16
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_ce_mhz,
  output logic o_ce
);

  localparam int c_w = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(par_ce_divisor - 1);

  logic [c_w-1:0] cnt_q;
  logic [c_w-1:0] cnt_d;

  // Pulse is decoded from the counter so the first enable after reset lands
  // exactly par_ce_divisor enabled cycles later.
  assign o_ce = i_ce_mhz && (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q;
    if (i_ce_mhz) begin
      cnt_d = (cnt_q == c_last) ? '0 : cnt_q + c_w'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pwm_palette_driver_channel.sv
// led_pwm_channel
//   One PWM channel: an 8-bit shadow of the palette value, a comparator
//   against the (possibly phase-shifted) period counter, and the output flop.
// Ports:
//   i_clk    system clock
//   i_srst   asynchronous active-high reset
//   i_tick   PWM tick enable
//   i_wrap   tick is the period wrap (counter 255 -> 0)
//   i_phase  counter value this channel compares against after the tick
//   i_value  live palette value, sampled only on the wrap tick
//   o_pwm    PWM output bit
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_tick,
  input  logic       i_wrap,
  input  logic [7:0] i_phase,
  input  logic [7:0] i_value,
  output logic       o_pwm
);

  t_pwm_value shadow_q;
  t_pwm_value shadow_d;
  logic       pwm_q;
  logic       pwm_d;

  always_comb begin
    shadow_d = shadow_q;
    pwm_d    = pwm_q;
    if (i_tick) begin
      if (i_wrap) begin
        // New period: the freshly loaded value decides the first tick, so
        // compare against the input rather than the stale shadow.
        shadow_d = i_value;
        pwm_d    = (i_phase < i_value);
      end else begin
        pwm_d    = (i_phase < shadow_q);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/led_pwm_palette_driver.sv
// led_pwm_palette_driver
//   Converts per-LED 8-bit palette values into one PWM bit per LED channel.
//   Values are double-buffered and only take effect at a PWM period wrap.
//   Optional feature macro: LED_PWM_PHASE_STAGGER_EN -- LED k of each group
//   compares against (counter + k*64) mod 256 to spread switching edges.
// Ports:
//   i_clk                    system clock
//   i_srst                   asynchronous active-high reset
//   i_color_led_*_value      red/green/blue palette, LED k at [8k+7:8k]
//   i_basic_led_lumin_value  basic LED luminance, same packing
//   o_color_led_*            red/green/blue PWM bit per color LED
//   o_basic_led_lumin        PWM bit per basic LED
module led_pwm_palette_driver
  import led_pwm_pkg::*;
#(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_pwm_freq_hz     = 9_765
) (
  input  logic                              i_clk,
  input  logic                              i_srst,
  input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
  input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0]   o_color_led_red,
  output logic [parm_color_led_count-1:0]   o_color_led_green,
  output logic [parm_color_led_count-1:0]   o_color_led_blue,
  output logic [parm_basic_led_count-1:0]   o_basic_led_lumin
);

  localparam int c_tick_divisor = calc_tick_divisor(parm_FCLK, parm_pwm_freq_hz);

  logic       s_pwm_ce;
  logic       s_wrap;
  t_pwm_value cnt_q;
  t_pwm_value cnt_d;
  t_pwm_value cnt_next;

  clock_enable_divider #(
    .par_ce_divisor (c_tick_divisor)
  ) u_tick_div (
    .i_clk    (i_clk),
    .i_srst   (i_srst),
    .i_ce_mhz (1'b1),
    .o_ce     (s_pwm_ce)
  );

  // Counter value after this tick; 255 + 1 wraps to 0 naturally.
  assign cnt_next = cnt_q + 8'd1;
  assign s_wrap   = s_pwm_ce && (cnt_q == 8'hFF);

  always_comb begin
    cnt_d = cnt_q;
    if (s_pwm_ce) cnt_d = cnt_next;
  end

  // Reset to 255 so the very first tick after release is a wrap and loads
  // fresh palette values.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) cnt_q <= 8'hFF;
    else        cnt_q <= cnt_d;
  end

  genvar gi;

  generate
    for (gi = 0; gi < parm_color_led_count; gi++) begin : g_color
      logic [7:0] phase;
`ifdef LED_PWM_PHASE_STAGGER_EN
      assign phase = cnt_next + 8'((gi * c_pwm_phase_step) % c_pwm_steps);
`else
      assign phase = cnt_next;
`endif

      led_pwm_channel u_red (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_tick  (s_pwm_ce),
        .i_wrap  (s_wrap),
        .i_phase (phase),
        .i_value (i_color_led_red_value[8*gi +: 8]),
        .o_pwm   (o_color_led_red[gi])
      );

      led_pwm_channel u_green (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_tick  (s_pwm_ce),
        .i_wrap  (s_wrap),
        .i_phase (phase),
        .i_value (i_color_led_green_value[8*gi +: 8]),
        .o_pwm   (o_color_led_green[gi])
      );

      led_pwm_channel u_blue (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_tick  (s_pwm_ce),
        .i_wrap  (s_wrap),
        .i_phase (phase),
        .i_value (i_color_led_blue_value[8*gi +: 8]),
        .o_pwm   (o_color_led_blue[gi])
      );
    end

    for (gi = 0; gi < parm_basic_led_count; gi++) begin : g_basic
      logic [7:0] phase;
`ifdef LED_PWM_PHASE_STAGGER_EN
      assign phase = cnt_next + 8'((gi * c_pwm_phase_step) % c_pwm_steps);
`else
      assign phase = cnt_next;
`endif

      led_pwm_channel u_lumin (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_tick  (s_pwm_ce),
        .i_wrap  (s_wrap),
        .i_phase (phase),
        .i_value (i_basic_led_lumin_value[8*gi +: 8]),
        .o_pwm   (o_basic_led_lumin[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_pwm_palette_driver.sv
// tb_led_pwm_palette_driver
//   Directed bench: one instance with a 1-cycle tick divisor for exact
//   per-tick timing, one with default parameters (divisor 16).
module tb_led_pwm_palette_driver;

`ifdef LED_PWM_PHASE_STAGGER_EN
  localparam bit c_stagger = 1'b1;
`else
  localparam bit c_stagger = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic [31:0] red_v, green_v, blue_v, basic_v;
  logic [3:0]  o_red, o_green, o_blue, o_basic;
  logic [31:0] d_red_v, d_green_v, d_blue_v, d_basic_v;
  logic [3:0]  d_red, d_green, d_blue, d_basic;

  led_pwm_palette_driver #(
    .parm_color_led_count (4),
    .parm_basic_led_count (4),
    .parm_FCLK            (256 * 9_765),
    .parm_pwm_freq_hz     (9_765)
  ) u_dut (
    .i_clk                   (clk),
    .i_srst                  (srst),
    .i_color_led_red_value   (red_v),
    .i_color_led_green_value (green_v),
    .i_color_led_blue_value  (blue_v),
    .i_basic_led_lumin_value (basic_v),
    .o_color_led_red         (o_red),
    .o_color_led_green       (o_green),
    .o_color_led_blue        (o_blue),
    .o_basic_led_lumin       (o_basic)
  );

  led_pwm_palette_driver u_dut_def (
    .i_clk                   (clk),
    .i_srst                  (srst),
    .i_color_led_red_value   (d_red_v),
    .i_color_led_green_value (d_green_v),
    .i_color_led_blue_value  (d_blue_v),
    .i_basic_led_lumin_value (d_basic_v),
    .o_color_led_red         (d_red),
    .o_color_led_green       (d_green),
    .o_color_led_blue        (d_blue),
    .o_basic_led_lumin       (d_basic)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] tb_cnt;
  int hi_r[4], hi_g[4], hi_b[4], hi_bs[4];
  int hi_others1;
  int hi_d_b3, hi_d_other;
  int rise_r[4];
  logic [3:0] prev_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      hi_r[k] = 0; hi_g[k] = 0; hi_b[k] = 0; hi_bs[k] = 0; rise_r[k] = -1;
    end
    hi_others1 = 0;
    hi_d_b3    = 0;
    hi_d_other = 0;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tb_cnt = tb_cnt + 8'd1;
      for (int k = 0; k < 4; k++) begin
        hi_r[k]  += int'(o_red[k]);
        hi_g[k]  += int'(o_green[k]);
        hi_b[k]  += int'(o_blue[k]);
        hi_bs[k] += int'(o_basic[k]);
        if (o_red[k] && !prev_r[k] && rise_r[k] < 0) rise_r[k] = int'(tb_cnt);
      end
      prev_r      = o_red;
      hi_others1 += $countones({o_red[3:1], o_green, o_blue, o_basic});
      hi_d_b3    += int'(d_blue[3]);
      hi_d_other += $countones({d_red, d_green, d_blue[2:0], d_basic});
    end
  endtask

  initial begin
    srst      = 1'b1;
    red_v     = '0; green_v   = '0; blue_v   = '0; basic_v   = '0;
    d_red_v   = '0; d_green_v = '0; d_blue_v = 32'h8000_0000; d_basic_v = '0;
    tb_cnt    = 8'hFF;
    prev_r    = '0;
    clear_counts();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {16'h0, o_red, o_green, o_blue, o_basic}, 32'h0);
    check_eq("rst_counter", {24'h0, u_dut.cnt_q}, 32'hFF);
    check_eq("rst_def_outputs", {16'h0, d_red, d_green, d_blue, d_basic}, 32'h0);

    // Red LED0 = 0x40, everything else 0
    @(negedge clk);
    red_v  = 32'h0000_0040;
    srst   = 1'b0;
    tb_cnt = 8'hFF;
    step(1);
    check_eq("first_wrap_red0", {31'h0, o_red[0]}, 32'h1);
    check_eq("first_wrap_cnt", {24'h0, u_dut.cnt_q}, {24'h0, tb_cnt});
    step(255);
    check_eq("red0_duty_p1", hi_r[0], 64);
    check_eq("others_zero_p1", hi_others1, 0);
    clear_counts();
    step(256);
    check_eq("red0_duty_p2", hi_r[0], 64);
    check_eq("basic2_zero", hi_bs[2], 0);

    // Basic LED2 = 0xFF (loaded at the next wrap, counter is at 255 now)
    basic_v = 32'h00FF_0000;
    clear_counts();
    step(256);
    check_eq("basic2_duty_ff", hi_bs[2], 255);
    check_eq("basic2_at_255", {31'h0, o_basic[2]}, c_stagger ? 32'h1 : 32'h0);

    // Green LED1: 0x10, then 0xC0 written at counter 100
    green_v = 32'h0000_1000;
    clear_counts();
    step(256);
    check_eq("green1_duty_10", hi_g[1], 16);
    clear_counts();
    step(101);
    check_eq("cnt_at_100", {24'h0, u_dut.cnt_q}, 32'd100);
    green_v = 32'h0000_C000;
    step(155);
    check_eq("green1_mid_change", hi_g[1], 16);
    clear_counts();
    step(1);
    check_eq("green1_new_at_wrap", {31'h0, o_green[1]}, 32'h1);
    step(255);
    check_eq("green1_duty_c0", hi_g[1], 192);

    // Asynchronous reset with outputs high
    step(11);
    check_eq("pre_rst_high", {29'h0, o_red[0], o_green[1], o_basic[2]}, 32'h7);
    @(posedge clk);
    #3;
    srst = 1'b1;
    #1;
    check_eq("async_rst_outputs", {16'h0, o_red, o_green, o_blue, o_basic}, 32'h0);
    check_eq("async_rst_def", {16'h0, d_red, d_green, d_blue, d_basic}, 32'h0);
    @(negedge clk);
    srst   = 1'b0;
    tb_cnt = 8'hFF;
    prev_r = '0;
    step(1);
    check_eq("post_rst_outputs", {16'h0, o_red, o_green, o_blue, o_basic}, 32'h1204);
    check_eq("post_rst_cnt", {24'h0, u_dut.cnt_q}, 32'h0);

    // Default-parameter instance: blue LED3 = 0x80, divisor 16
    step(20);
    clear_counts();
    step(4096);
    check_eq("def_blue3_duty", hi_d_b3, 2048);
    check_eq("def_others_zero", hi_d_other, 0);

    // All four reds = 0x40: phase alignment / stagger
    red_v = 32'h4040_4040;
    step(int'(8'hFF - tb_cnt));
    clear_counts();
    prev_r = o_red;
    step(256);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("red%0d_rise_cnt", k), rise_r[k],
               c_stagger ? ((256 - 64 * k) % 256) : 0);
      check_eq($sformatf("red%0d_duty", k), hi_r[k], 64);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
